// File: rtl/cntr_pkg.sv
// Shared constants for the up/down counter family: default width and terminal value.
// Pure declarations; no logic, latency or flow control.
package cntr_pkg;

    localparam int CNTR_WIDTH = 4;

    // Default terminal value for a counter of width w: all ones.
    function automatic int cntr_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/up_cntr_if.sv
// Control/status bundle of the up-counter: enable, load, overflow clear in; count, tc, ovf out.
// Plain wires; the slave registers every input on the next rising edge, and there is no backpressure.
interface up_cntr_if
    import cntr_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] ld_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] z;
    logic             tc;
    logic             ovf;

    modport master (
        output en, load, ld_val, clr_ovf,
        input  z, tc, ovf
    );

    modport slave (
        input  en, load, ld_val, clr_ovf,
        output z, tc, ovf
    );
endinterface

// File: rtl/up_cntr_add_one.sv
// Combinational incrementer: y = x+1 at WIDTH+1 bits, at_max flags that x+1 would pass MAX_VAL.
// Zero latency; no flow control.
module add_one #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15
) (
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y,
    output logic             o_at_max
);
    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);

    logic [WIDTH:0] w_sum;

    assign w_sum    = {1'b0, i_x} + {{WIDTH{1'b0}}, 1'b1};
    // Wrap is decided by the compare, so a non-power-of-two MAX_VAL needs no 2^WIDTH rollover.
    assign o_at_max = (w_sum > MAXV);
    assign o_y      = w_sum[WIDTH-1:0];
endmodule

// File: rtl/up_cntr.sv
// Synchronous up-counter 0..MAX_VAL with clamped load, tc pulse and sticky ovf; SATURATE_EN holds at MAX_VAL.
// One-edge latency from every input to z/tc/ovf; always ready, no backpressure.
module up_cntr
    import cntr_pkg::*;
#(
    parameter int WIDTH   = CNTR_WIDTH,
    parameter int MAX_VAL = cntr_max(WIDTH)
) (
    input  logic     clk,
    input  logic     reset,
    up_cntr_if.slave bus
);
    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);

    logic [WIDTH-1:0] r_z;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_inc;
    logic             w_at_max;
    logic [WIDTH-1:0] w_ld_clamp;

    add_one #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_add_one (
        .i_x      (r_z),
        .o_y      (w_inc),
        .o_at_max (w_at_max)
    );

    assign w_ld_clamp = ({1'b0, bus.ld_val} > MAXV) ? MAXV[WIDTH-1:0] : bus.ld_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_z   <= '0;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
            // Later assignments below let a wrap/saturation set override a same-edge clear.
            if (bus.load) begin
                r_z <= w_ld_clamp;
            end else if (bus.en) begin
                if (w_at_max) begin
`ifdef SATURATE_EN
                    r_ovf <= 1'b1;
`else
                    r_z   <= '0;
                    r_tc  <= 1'b1;
                    r_ovf <= 1'b1;
`endif
                end else begin
                    r_z <= w_inc;
                end
            end
        end
    end

    assign bus.z   = r_z;
    assign bus.tc  = r_tc;
    assign bus.ovf = r_ovf;
endmodule
